vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_timing_gen.sv | 80 ++++++++
 tb/tb_vga_timing_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing, the totals and sync windows derived from it,
// and the 10-bit coordinate type shared by the timing generator and its axis counters.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF  = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF  = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int HS_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int VS_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

  localparam int COORD_W    = 10;
  localparam int COORD_SPAN = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with enable, a wrap pulse, and sync/active
// window flags registered from the next count so they line up with o_count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL           = H_TOTAL_DEF,
  parameter int ACTIVE          = H_DISPLAY_DEF,
  parameter int SYNC_START      = HS_START_DEF,
  parameter int SYNC_END        = HS_END_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_en,
  output coord_t o_count,
  output logic   o_wrap,
  output logic   o_sync,
  output logic   o_active
);

  localparam coord_t LAST     = coord_t'(TOTAL - 1);
  localparam coord_t SS       = coord_t'(SYNC_START);
  localparam coord_t SE       = coord_t'(SYNC_END);
  localparam coord_t ACT      = coord_t'(ACTIVE);
  localparam logic   SYNC_ON  = ~SYNC_ACTIVE_LOW;

  coord_t r_count;
  logic   r_sync;
  logic   r_active;
  coord_t w_next;
  logic   w_in_sync;

  assign o_wrap = i_en && (r_count == LAST);

  always_comb begin
    w_next = r_count;
    if (o_wrap) begin
      w_next = '0;
    end else if (i_en) begin
      w_next = r_count + coord_t'(1);
    end
  end

  assign w_in_sync = (w_next >= SS) && (w_next <= SE);

  // The pin level is registered directly, so polarity costs no output logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_sync   <= ~SYNC_ON;
      r_active <= 1'b1;
    end else begin
      r_count  <= w_next;
      r_sync   <= w_in_sync ? SYNC_ON : ~SYNC_ON;
      r_active <= (w_next < ACT);
    end
  end

  assign o_count  = r_count;
  assign o_sync   = r_sync;
  assign o_active = r_active;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: horizontal axis counts every pixel clock,
// vertical axis advances on each line wrap; syncs, display_on and coordinates are aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  if (H_TOTAL > COORD_SPAN || V_TOTAL > COORD_SPAN) begin : g_param_err
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end

  coord_t w_hcount;
  coord_t w_vcount;
  logic   w_h_wrap;
  logic   w_v_wrap_unused;
  logic   w_h_active;
  logic   w_v_active;

  vga_axis_counter #(
    .TOTAL          (H_TOTAL),
    .ACTIVE         (H_DISPLAY),
    .SYNC_START     (HS_START),
    .SYNC_END       (HS_END),
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_h_axis (
    .clk     (clk),
    .reset   (reset),
    .i_en    (1'b1),
    .o_count (w_hcount),
    .o_wrap  (w_h_wrap),
    .o_sync  (hsync),
    .o_active(w_h_active)
  );

  vga_axis_counter #(
    .TOTAL          (V_TOTAL),
    .ACTIVE         (V_DISPLAY),
    .SYNC_START     (VS_START),
    .SYNC_END       (VS_END),
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_v_axis (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_h_wrap),
    .o_count (w_vcount),
    .o_wrap  (w_v_wrap_unused),
    .o_sync  (vsync),
    .o_active(w_v_active)
  );

  // Both window flags are flops, so display_on depends on state only, never on inputs.
  assign display_on = w_h_active & w_v_active;
  assign hpos       = w_hcount;
  assign vpos       = w_vcount;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: default, inverted-polarity, short-frame and tiny-timing generators
// run side by side against an independent raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  logic       def_hs, def_vs, def_de, inv_hs, inv_vs, inv_de;
  logic       mid_hs, mid_vs, mid_de, sml_hs, sml_vs, sml_de;
  logic [9:0] def_h, def_v, inv_h, inv_v, mid_h, mid_v, sml_h, sml_v;

  vga_timing_gen u_def (
    .clk(clk), .reset(reset), .hsync(def_hs), .vsync(def_vs),
    .display_on(def_de), .hpos(def_h), .vpos(def_v)
  );

  vga_timing_gen #(.SYNC_ACTIVE_LOW(1'b0)) u_inv (
    .clk(clk), .reset(reset), .hsync(inv_hs), .vsync(inv_vs),
    .display_on(inv_de), .hpos(inv_h), .vpos(inv_v)
  );

  vga_timing_gen #(.V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) u_mid (
    .clk(clk), .reset(reset), .hsync(mid_hs), .vsync(mid_vs),
    .display_on(mid_de), .hpos(mid_h), .vpos(mid_v)
  );

  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                   .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_sml (
    .clk(clk), .reset(reset), .hsync(sml_hs), .vsync(sml_vs),
    .display_on(sml_de), .hpos(sml_h), .vpos(sml_v)
  );

  // Model configurations: 0 = default, 1 = short frame, 2 = tiny timing.
  int hd[3]  = '{640, 640, 8};
  int hf[3]  = '{16, 16, 2};
  int hsw[3] = '{96, 96, 2};
  int hb[3]  = '{48, 48, 2};
  int vd[3]  = '{480, 6, 4};
  int vf[3]  = '{10, 2, 1};
  int vsw[3] = '{2, 2, 1};
  int vb[3]  = '{33, 2, 1};
  int mh[3]  = '{0, 0, 0};
  int mv[3]  = '{0, 0, 0};

  logic [22:0] sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic step(input logic rst);
    logic [22:0] got, exp;
    int ht, vt, hs0, vs0;
    logic e_hs, e_vs, e_de;
    @(negedge clk);
    reset = rst;
    for (int c = 0; c < 3; c++) begin
      ht = hd[c] + hf[c] + hsw[c] + hb[c];
      vt = vd[c] + vf[c] + vsw[c] + vb[c];
      if (rst) begin
        mh[c] = 0;
        mv[c] = 0;
      end else if (mh[c] == ht - 1) begin
        mh[c] = 0;
        mv[c] = (mv[c] == vt - 1) ? 0 : mv[c] + 1;
      end else begin
        mh[c] = mh[c] + 1;
      end
      hs0  = hd[c] + hf[c];
      vs0  = vd[c] + vf[c];
      e_hs = !(mh[c] >= hs0 && mh[c] < hs0 + hsw[c]);
      e_vs = !(mv[c] >= vs0 && mv[c] < vs0 + vsw[c]);
      e_de = (mh[c] < hd[c]) && (mv[c] < vd[c]);
      sb.push_back({e_hs, e_vs, e_de, 10'(mh[c]), 10'(mv[c])});
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < 3; c++) begin
      exp = sb.pop_front();
      case (c)
        0:       got = {def_hs, def_vs, def_de, def_h, def_v};
        1:       got = {mid_hs, mid_vs, mid_de, mid_h, mid_v};
        default: got = {sml_hs, sml_vs, sml_de, sml_h, sml_v};
      endcase
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sb_cfg%0d cyc=%0d got hs/vs/de/h/v=%b%b%b/%0d/%0d required %b%b%b/%0d/%0d",
                 c, cyc, got[22], got[21], got[20], got[19:10], got[9:0],
                 exp[22], exp[21], exp[20], exp[19:10], exp[9:0]);
      end
    end
    checks++;
    if ({inv_hs, inv_vs} !== ~{def_hs, def_vs} || {inv_de, inv_h, inv_v} !== {def_de, def_h, def_v}) begin
      errors++;
      $display("FAIL polarity cyc=%0d got inv hs/vs=%b%b de=%b h=%0d v=%0d required hs/vs=%b%b de=%b h=%0d v=%0d",
               cyc, inv_hs, inv_vs, inv_de, inv_h, inv_v, ~def_hs, ~def_vs, def_de, def_h, def_v);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1);
    checks++;
    if ({def_h, def_v, def_hs, def_vs, def_de} !== {10'd0, 10'd0, 3'b111}) begin
      errors++;
      $display("FAIL reset_state got h=%0d v=%0d hs=%b vs=%b de=%b required 0 0 1 1 1",
               def_h, def_v, def_hs, def_vs, def_de);
    end
    checks++;
    if ({inv_hs, inv_vs} !== 2'b00) begin
      errors++;
      $display("FAIL reset_inv_sync got %b%b required 00", inv_hs, inv_vs);
    end
    step(1'b0);
    checks++;
    if (def_h !== 10'd1 || def_v !== 10'd0) begin
      errors++;
      $display("FAIL first_count got h=%0d v=%0d required 1 0", def_h, def_v);
    end
  endtask

  task automatic test_line();
    logic p_hs, p_de;
    int p_h;
    int fall_h = -1;
    int rise_h = -1;
    int de_fall_h = -1;
    bit wrapped = 1'b0;
    for (int i = 0; i < 900; i++) begin
      p_hs = def_hs;
      p_de = def_de;
      p_h  = int'(def_h);
      step(1'b0);
      if (p_hs && !def_hs && fall_h < 0) fall_h = int'(def_h);
      if (!p_hs && def_hs && rise_h < 0) rise_h = int'(def_h);
      if (p_de && !def_de && de_fall_h < 0) de_fall_h = int'(def_h);
      if (p_h == 799 && !wrapped) begin
        wrapped = 1'b1;
        checks++;
        if (def_h !== 10'd0 || def_v !== 10'd1) begin
          errors++;
          $display("FAIL line_wrap got h=%0d v=%0d required 0 1", def_h, def_v);
        end
      end
    end
    checks++;
    if (fall_h != 656) begin errors++; $display("FAIL hsync_fall got hpos %0d required 656", fall_h); end
    checks++;
    if (rise_h != 752) begin errors++; $display("FAIL hsync_rise got hpos %0d required 752", rise_h); end
    checks++;
    if (de_fall_h != 640) begin errors++; $display("FAIL de_fall got hpos %0d required 640", de_fall_h); end
    checks++;
    if (!wrapped) begin errors++; $display("FAIL line_wrap got no wrap required wrap at 799"); end
  endtask

  task automatic test_frame();
    logic pm_vs, ps_vs;
    int pm_h, pm_v, ps_h, ps_v;
    int lf_m = -1, per_m = -1, lf_s = -1, per_s = -1;
    int low_run = 0, low_m = 0, de_bad = 0;
    bit mw = 1'b0, sw = 1'b0;
    for (int i = 0; i < 17000; i++) begin
      pm_vs = mid_vs; pm_h = int'(mid_h); pm_v = int'(mid_v);
      ps_vs = sml_vs; ps_h = int'(sml_h); ps_v = int'(sml_v);
      step(1'b0);
      if (pm_vs && !mid_vs) begin
        if (lf_m >= 0 && per_m < 0) per_m = cyc - lf_m;
        lf_m = cyc;
      end
      if (ps_vs && !sml_vs) begin
        if (lf_s >= 0 && per_s < 0) per_s = cyc - lf_s;
        lf_s = cyc;
      end
      if (!mid_vs) low_run++;
      else if (low_run > 0) begin
        if (low_m == 0) low_m = low_run;
        low_run = 0;
      end
      if (mid_de && mid_v >= 10'd6) de_bad++;
      if (pm_h == 799 && pm_v == 11 && !mw) begin
        mw = 1'b1;
        checks++;
        if (mid_h !== 10'd0 || mid_v !== 10'd0) begin
          errors++;
          $display("FAIL mid_frame_wrap got h=%0d v=%0d required 0 0", mid_h, mid_v);
        end
      end
      if (ps_h == 13 && ps_v == 6 && !sw) begin
        sw = 1'b1;
        checks++;
        if (sml_h !== 10'd0 || sml_v !== 10'd0) begin
          errors++;
          $display("FAIL sml_frame_wrap got h=%0d v=%0d required 0 0", sml_h, sml_v);
        end
      end
    end
    checks++;
    if (per_m != 9600) begin errors++; $display("FAIL mid_vsync_period got %0d required 9600", per_m); end
    checks++;
    if (per_s != 98) begin errors++; $display("FAIL sml_vsync_period got %0d required 98", per_s); end
    checks++;
    if (low_m != 1600) begin errors++; $display("FAIL mid_vsync_width got %0d required 1600", low_m); end
    checks++;
    if (de_bad != 0) begin errors++; $display("FAIL mid_blank_lines got %0d visible cycles required 0", de_bad); end
    checks++;
    if (!mw || !sw) begin errors++; $display("FAIL frame_wrap_seen got mid=%0d sml=%0d required 1 1", mw, sw); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (def_h !== 10'd300 && n < 2000) begin
      step(1'b0);
      n++;
    end
    checks++;
    if (def_h !== 10'd300) begin
      errors++;
      $display("FAIL reach_300 got hpos %0d required 300", def_h);
    end
    step(1'b1);
    checks++;
    if ({def_h, def_v, def_hs, def_vs, def_de} !== {10'd0, 10'd0, 3'b111}) begin
      errors++;
      $display("FAIL midframe_reset got h=%0d v=%0d hs=%b vs=%b de=%b required 0 0 1 1 1",
               def_h, def_v, def_hs, def_vs, def_de);
    end
    checks++;
    if ({sml_h, sml_v} !== 20'd0) begin
      errors++;
      $display("FAIL midframe_reset_sml got h=%0d v=%0d required 0 0", sml_h, sml_v);
    end
    step(1'b0);
    checks++;
    if (def_h !== 10'd1 || def_v !== 10'd0) begin
      errors++;
      $display("FAIL resume got h=%0d v=%0d required 1 0", def_h, def_v);
    end
    for (int i = 0; i < 900; i++) step(1'b0);
    checks++;
    if (def_h !== 10'd101 || def_v !== 10'd1) begin
      errors++;
      $display("FAIL resume_line got h=%0d v=%0d required 101 1", def_h, def_v);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no finish required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
